// File: rtl/risc_v_mike_pkg.sv
// Shared types and constants for the risc_v_mike immediate generator.
package risc_v_mike_pkg;

  typedef enum logic [2:0] {
    ImmI       = 3'd0,
    ImmS       = 3'd1,
    ImmB       = 3'd2,
    ImmJ       = 3'd3,
    ImmU       = 3'd4,
    ImmZ       = 3'd5,
    ImmNone    = 3'd6,
    ImmIllegal = 3'd7
  } imm_fmt_t;

  localparam int unsigned XLEN_MAX   = 64;
  localparam int unsigned INSTR_32_W = 32;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/risc_v_mike_imm_gen_pipe_if.sv
// Valid/ready input and output bundle of the immediate generator pipeline slot.
interface risc_v_mike_imm_gen_pipe_if
  import risc_v_mike_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ERR_CNT_W = 16
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [INSTR_32_W-1:0] instruction;
  logic [2:0]            imm_src;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       imm_ext;
  logic [INSTR_32_W-1:0] instr_out;
  logic                  fmt_err;
  logic [ERR_CNT_W-1:0]  err_cnt;

  modport master (
    output in_valid, instruction, imm_src, out_ready,
    input  in_ready, out_valid, imm_ext, instr_out, fmt_err, err_cnt
  );

  modport slave (
    input  in_valid, instruction, imm_src, out_ready,
    output in_ready, out_valid, imm_ext, instr_out, fmt_err, err_cnt
  );
endinterface

// File: rtl/risc_v_mike_imm_gen_pipe_fmt_decode.sv
// Combinational opcode/funct3 to immediate-format decode.
// RISC_V_MIKE_IMM_CSR_EN routes CSR-immediate SYSTEM forms to the Z format.
module risc_v_mike_imm_fmt_decode
  import risc_v_mike_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  output imm_fmt_t   fmt_o
);
  logic unused_funct3;
  assign unused_funct3 = ^funct3_i[1:0];

  always_comb begin
    fmt_o = ImmIllegal;
    case (opcode_i)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt_o = ImmI;
      OPC_STORE:                      fmt_o = ImmS;
      OPC_BRANCH:                     fmt_o = ImmB;
      OPC_JAL:                        fmt_o = ImmJ;
      OPC_LUI, OPC_AUIPC:             fmt_o = ImmU;
      OPC_OP, OPC_FENCE:              fmt_o = ImmNone;
`ifdef RISC_V_MIKE_IMM_CSR_EN
      OPC_SYSTEM:                     fmt_o = funct3_i[2] ? ImmZ : ImmI;
`else
      OPC_SYSTEM:                     fmt_o = funct3_i[2] ? ImmI : ImmI;
`endif
      default:                        fmt_o = ImmIllegal;
    endcase
  end
endmodule

// File: rtl/risc_v_mike_imm_gen_pipe.sv
// Registered RISC-V immediate generator: one valid/ready pipeline slot plus error counter.
// RISC_V_MIKE_IMM_CSR_EN enables the zero-extended CSR immediate (Z) format.
module risc_v_mike_imm_gen_pipe
  import risc_v_mike_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned AUTO_DECODE = 0,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input logic                       clk,
  input logic                       rst,
  risc_v_mike_imm_gen_pipe_if.slave bus
);
  imm_fmt_t              fmt;
  logic [XLEN_MAX-1:0]   imm_full;
  logic [INSTR_32_W-1:0] instr;
  logic                  fmt_illegal;
  logic                  accept;
  logic                  unused_imm_full;

  logic                  out_valid_q, out_valid_d;
  logic [XLEN-1:0]       imm_q, imm_d;
  logic [INSTR_32_W-1:0] instr_q, instr_d;
  logic                  fmt_err_q, fmt_err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  assign instr = bus.instruction;

  if (AUTO_DECODE != 0) begin : g_auto
    logic unused_imm_src;
    assign unused_imm_src = ^bus.imm_src;
    risc_v_mike_imm_fmt_decode u_fmt_decode (
      .opcode_i (instr[6:0]),
      .funct3_i (instr[14:12]),
      .fmt_o    (fmt)
    );
  end else begin : g_manual
    assign fmt = imm_fmt_t'(bus.imm_src);
  end

  // Build at XLEN_MAX and truncate, so one mux serves both widths.
  always_comb begin
    imm_full    = '0;
    fmt_illegal = 1'b0;
    case (fmt)
      ImmI:    imm_full = {{52{instr[31]}}, instr[31:20]};
      ImmS:    imm_full = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:    imm_full = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmJ:    imm_full = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                           1'b0};
      ImmU:    imm_full = {{32{instr[31]}}, instr[31:12], 12'b0};
`ifdef RISC_V_MIKE_IMM_CSR_EN
      ImmZ:    imm_full = {59'b0, instr[19:15]};
`else
      ImmZ:    fmt_illegal = 1'b1;
`endif
      ImmNone: imm_full = '0;
      default: fmt_illegal = 1'b1;
    endcase
  end

  assign unused_imm_full = ^imm_full;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    imm_d       = imm_q;
    instr_d     = instr_q;
    fmt_err_d   = fmt_err_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      imm_d       = fmt_illegal ? '0 : imm_full[XLEN-1:0];
      instr_d     = instr;
      fmt_err_d   = fmt_illegal;
      if (fmt_illegal && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      instr_q     <= '0;
      fmt_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      imm_q       <= imm_d;
      instr_q     <= instr_d;
      fmt_err_q   <= fmt_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.imm_ext   = imm_q;
  assign bus.instr_out = instr_q;
  assign bus.fmt_err   = fmt_err_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule
